// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl: ball motion, paddle/wall bounces, miss detection and rally scoring
module pong_ball_ctrl #(
    parameter int H_MAX       = 639,
    parameter int V_MAX       = 479,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_H    = 64,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_XL   = 16,
    parameter int PADDLE_XR   = 616,
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_TICKS = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic [9:0] paddle_l_y,
    input  logic [9:0] paddle_r_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [2:0] score_l,
    output logic [2:0] score_r,
    output logic       point_l,
    output logic       point_r,
    output logic       game_over,
    output logic [2:0] state
);
    typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, SCORED = 3'd3, OVER = 3'd4} state_t;
    localparam int CW = $clog2(SERVE_TICKS + 1);
    localparam logic [9:0] CX     = 10'((H_MAX + 1 - BALL_SIZE) / 2);
    localparam logic [9:0] CY     = 10'((V_MAX + 1 - BALL_SIZE) / 2);
    localparam logic [9:0] X_MAX  = 10'(H_MAX + 1 - BALL_SIZE);
    localparam logic [9:0] Y_MAX  = 10'(V_MAX + 1 - BALL_SIZE);
    localparam logic [9:0] X_LHIT = 10'(PADDLE_XL + PADDLE_W);
    localparam logic [9:0] X_RHIT = 10'(PADDLE_XR - BALL_SIZE);
    localparam logic [2:0] WIN    = 3'(WIN_SCORE);
    state_t st, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [9:0] x_n, y_n;
    logic [2:0] sl_n, sr_n;
    logic dx, dx_n, dy, dy_n, pl_n, pr_n;
    logic hit_l, hit_r;
    assign state = st;
    // paddle overlap uses 11-bit sums so paddles near the bottom of the range cannot wrap
    assign hit_l = ({1'b0, ball_y} + 11'(BALL_SIZE) > {1'b0, paddle_l_y}) &&
                   ({1'b0, ball_y} < {1'b0, paddle_l_y} + 11'(PADDLE_H));
    assign hit_r = ({1'b0, ball_y} + 11'(BALL_SIZE) > {1'b0, paddle_r_y}) &&
                   ({1'b0, ball_y} < {1'b0, paddle_r_y} + 11'(PADDLE_H));
    // next-state and next-output computation; dx=1 means right, dy=1 means down
    always_comb begin
        st_n  = st;
        cnt_n = cnt;
        x_n   = ball_x;
        y_n   = ball_y;
        dx_n  = dx;
        dy_n  = dy;
        sl_n  = score_l;
        sr_n  = score_r;
        pl_n  = 1'b0;
        pr_n  = 1'b0;
        case (st)
            IDLE, OVER: begin
                if (start) begin
                    st_n  = SERVE;
                    cnt_n = '0;
                    x_n   = CX;
                    y_n   = CY;
                    dx_n  = 1'b1;
                    dy_n  = 1'b1;
                    sl_n  = '0;
                    sr_n  = '0;
                end
            end
            SERVE: begin
                if (tick) begin
                    cnt_n = cnt + CW'(1);
                    st_n  = (cnt_n == CW'(SERVE_TICKS)) ? PLAY : SERVE;
                end
            end
            PLAY: begin
                if (tick) begin
                    if (!dy && ball_y == 10'd0) begin
                        dy_n = 1'b1;
                        y_n  = 10'd1;
                    end else if (dy && ball_y == Y_MAX) begin
                        dy_n = 1'b0;
                        y_n  = Y_MAX - 10'd1;
                    end else begin
                        y_n = dy ? ball_y + 10'd1 : ball_y - 10'd1;
                    end
                    if (!dx && ball_x == X_LHIT && hit_l) begin
                        dx_n = 1'b1;
                        x_n  = X_LHIT + 10'd1;
                    end else if (dx && ball_x == X_RHIT && hit_r) begin
                        dx_n = 1'b0;
                        x_n  = X_RHIT - 10'd1;
                    end else if (!dx && ball_x == 10'd0) begin
                        sr_n = (score_r == 3'd7) ? 3'd7 : score_r + 3'd1;
                        pr_n = 1'b1;
                        st_n = SCORED;
                        y_n  = ball_y;
                        dy_n = dy;
                    end else if (dx && ball_x == X_MAX) begin
                        sl_n = (score_l == 3'd7) ? 3'd7 : score_l + 3'd1;
                        pl_n = 1'b1;
                        st_n = SCORED;
                        y_n  = ball_y;
                        dy_n = dy;
                    end else begin
                        x_n = dx ? ball_x + 10'd1 : ball_x - 10'd1;
                    end
                end
            end
            SCORED: begin
                if (score_l == WIN || score_r == WIN) begin
                    st_n = OVER;
                end else begin
                    st_n  = SERVE;
                    cnt_n = '0;
                    x_n   = CX;
                    y_n   = CY;
                    dy_n  = 1'b1;
                    dx_n  = point_l;
                end
            end
            default: st_n = IDLE;
        endcase
    end
    // state and output registers, cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            cnt       <= '0;
            ball_x    <= CX;
            ball_y    <= CY;
            dx        <= 1'b1;
            dy        <= 1'b1;
            score_l   <= '0;
            score_r   <= '0;
            point_l   <= 1'b0;
            point_r   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            st        <= st_n;
            cnt       <= cnt_n;
            ball_x    <= x_n;
            ball_y    <= y_n;
            dx        <= dx_n;
            dy        <= dy_n;
            score_l   <= sl_n;
            score_r   <= sr_n;
            point_l   <= pl_n;
            point_r   <= pr_n;
            game_over <= (st_n == OVER);
        end
    end
endmodule

// File: tb/tb_pong_ball_ctrl.sv
// tb_pong_ball_ctrl: randomized rallies checked against a velocity-based reference model
module tb_pong_ball_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [9:0] paddle_l_y = '0;
    logic [9:0] paddle_r_y = '0;
    logic [9:0] ball_x, ball_y;
    logic [2:0] score_l, score_r, state;
    logic       point_l, point_r, game_over;

    pong_ball_ctrl dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start),
        .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
        .ball_x(ball_x), .ball_y(ball_y), .score_l(score_l), .score_r(score_r),
        .point_l(point_l), .point_r(point_r), .game_over(game_over), .state(state)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int m_st, m_x, m_y, m_vx, m_vy, m_sl, m_sr, m_cnt, m_ppl, m_ppr, m_last_l;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("state", 32'(state), m_st);
        chk("ball_x", 32'(ball_x), m_x);
        chk("ball_y", 32'(ball_y), m_y);
        chk("score_l", 32'(score_l), m_sl);
        chk("score_r", 32'(score_r), m_sr);
        chk("point_l", 32'(point_l), m_ppl);
        chk("point_r", 32'(point_r), m_ppr);
        chk("game_over", 32'(game_over), (m_st == 4) ? 1 : 0);
    endtask

    task automatic model_reset();
        m_st = 0; m_x = 316; m_y = 236; m_vx = 1; m_vy = 1;
        m_sl = 0; m_sr = 0; m_cnt = 0; m_ppl = 0; m_ppr = 0; m_last_l = 0;
    endtask

    task automatic serve_setup();
        m_st = 1; m_x = 316; m_y = 236; m_vy = 1; m_cnt = 0;
    endtask

    // reference: ball position plus velocity; a step outside the field is a wall bounce or a miss
    task automatic model_step(input bit s, input bit t, input int pl, input int pr);
        int ny;
        bit hl, hr;
        m_ppl = 0;
        m_ppr = 0;
        case (m_st)
            0, 4: if (s) begin
                serve_setup();
                m_vx = 1; m_sl = 0; m_sr = 0;
            end
            1: if (t) begin
                m_cnt++;
                if (m_cnt == 60) m_st = 2;
            end
            2: if (t) begin
                if (m_x + m_vx < 0 || m_x + m_vx > 632) begin
                    if (m_vx < 0) begin
                        m_sr = (m_sr < 7) ? m_sr + 1 : 7; m_ppr = 1; m_last_l = 0;
                    end else begin
                        m_sl = (m_sl < 7) ? m_sl + 1 : 7; m_ppl = 1; m_last_l = 1;
                    end
                    m_st = 3;
                end else begin
                    hl = (m_vx < 0) && (m_x == 24) && (m_y + 8 > pl) && (m_y < pl + 64);
                    hr = (m_vx > 0) && (m_x == 608) && (m_y + 8 > pr) && (m_y < pr + 64);
                    ny = m_y + m_vy;
                    if (ny < 0 || ny > 472) begin
                        m_vy = -m_vy;
                        ny = m_y + m_vy;
                    end
                    m_y = ny;
                    if (hl || hr) m_vx = -m_vx;
                    m_x = m_x + m_vx;
                end
            end
            3: if (m_sl == 7 || m_sr == 7) m_st = 4;
               else begin
                   serve_setup();
                   m_vx = m_last_l ? 1 : -1;
               end
            default: ;
        endcase
    endtask

    function automatic int trk();
        int v;
        v = m_y - int'($urandom_range(0, 55));
        return (v < 0) ? 0 : v;
    endfunction

    task automatic cyc(input bit s, input bit t, input int pl, input int pr);
        start = s;
        tick = t;
        paddle_l_y = 10'(pl);
        paddle_r_y = 10'(pr);
        @(posedge clk);
        #1;
        model_step(s, t, pl, pr);
        check_all();
        start = 1'b0;
        tick = 1'b0;
    endtask

    initial begin
        int guard;
        int sl_hits;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (60) cyc(0, 1, 0, 0);
        // long rally with both paddles tracking: walls and both paddle faces
        repeat (2000) cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, trk(), trk());
        // lopsided play to a finished game; paddles sometimes anywhere in the 10-bit range
        guard = 0;
        sl_hits = 0;
        while (m_st != 4 && guard < 60000) begin
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                ($urandom_range(0, 9) < 8) ? trk() : int'($urandom_range(0, 1023)),
                ($urandom_range(0, 9) < 2) ? trk() : int'($urandom_range(0, 1023)));
            if (m_ppl == 1) sl_hits++;
            guard++;
        end
        chk("reached_over", (m_st == 4) ? 1 : 0, 1);
        chk("left_points", (sl_hits > 0) ? 1 : 0, 1);
        repeat (20) cyc(0, $urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 1023));
        cyc(1, 1, 0, 0);
        repeat (60) cyc(0, 1, 0, 0);
        repeat (100) cyc(0, 1, trk(), trk());
        chk("mid_play", 32'(state), 2);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1, 1, 0, 0);
        repeat (5) cyc(0, 1, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
